// File: rtl/secuenciador_mul.sv
// rtl/secuenciador_mul.sv - shift-and-add RV32 MUL sequencer borrowing the shared ALU adder
// One multiplier bit per granted cycle; the ALU performs ACC + (OPA << i).
module secuenciador_mul #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] OPA,
  input  logic [31:0] OPB,
  output logic [31:0] ALU_X,
  output logic [31:0] ALU_Y,
  output logic [3:0]  ALU_CONTROL,
  input  logic [31:0] ALU_RESULTADO,
  output logic        ALU_REQ,
  input  logic        ALU_GNT,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] PRODUCTO
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        req_q, req_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          m_d     = OPA;
          b_d     = OPB;
          acc_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Without a grant the adder output belongs to someone else: hold everything.
        if (ALU_GNT) begin
          if (b_q[0]) begin
            acc_d = ALU_RESULTADO;
          end
          m_d   = {m_q[30:0], 1'b0};
          b_d   = {1'b0, b_q[31:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31 || (EARLY_EXIT && b_q[31:1] == 31'd0)) begin
            state_d = ST_FIN;
            prod_d  = acc_d;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    req_d  = (state_d == ST_CALC);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      acc_q   <= 32'd0;
      m_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 5'd0;
      prod_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
    end
  end

  // Operands are driven only while the ALU is requested, so idle cycles present zeros.
  assign ALU_X       = req_q ? acc_q : 32'd0;
  assign ALU_Y       = req_q ? m_q : 32'd0;
  assign ALU_CONTROL = 4'b0000;
  assign ALU_REQ     = req_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PRODUCTO    = prod_q;

endmodule

// File: doc/secuenciador_mul.md
# secuenciador_mul

Multicycle multiply sequencer that computes the low 32 bits of OPA×OPB (RV32M MUL semantics: identical for signed and unsigned operands) by driving the shared ALU's ADD operation once per multiplier bit. It sits beside the ALU in the execute stage. It requests the ALU through a request/grant pair so the main datapath arbiter can lend it the ALU between ordinary instructions. It holds the core's result port with a START/BUSY/DONE handshake.

## Interface
- EARLY_EXIT, default 1: when 1, iteration stops once the remaining multiplier bits are all zero; when 0, always 32 iterations.
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high; clears all state immediately.
- START  in  1  request a multiply; sampled only in IDLE.
- OPA  in  32  multiplicand, captured when START accepted.
- OPB  in  32  multiplier, captured when START accepted.
- ALU_X  out  32  ALU operand X (accumulator).
- ALU_Y  out  32  ALU operand Y (shifted multiplicand).
- ALU_CONTROL  out  4  ALU operation select; constant 4'b0000 (ADD).
- ALU_RESULTADO  in  32  ALU result, consumed combinationally in the same cycle.
- ALU_REQ  out  1  ALU requested; high exactly while in CALC.
- ALU_GNT  in  1  ALU granted this cycle; CALC advances only when high.
- BUSY  out  1  high in CALC and FIN.
- DONE  out  1  one-cycle pulse, high in FIN.
- PRODUCTO  out  32  low 32 bits of the product; updated on entry to FIN, held until the next update.

## Operation
- Internal registers: ACC[31:0], M[31:0], B[31:0], CNT[4:0], and state ∈ {IDLE, CALC, FIN}.
- IDLE: if START=1, load M←OPA, B←OPB, ACC←0, CNT←0, and go to CALC. START=0 stays in IDLE.
- CALC with ALU_GNT=0: all registers hold and the state stays in CALC (stall). ALU_REQ stays high.
- CALC with ALU_GNT=1, one iteration per cycle:
  - If B[0]=1, ACC←ALU_RESULTADO; otherwise ACC holds.
  - M←M<<1 (logical); B←B>>1 (logical); CNT←CNT+1.
  - Go to FIN when CNT=31. If EARLY_EXIT=1, also go to FIN when (B>>1)=0.
  - On the transition to FIN, load PRODUCTO with the ACC value being written this cycle.
- FIN: DONE=1 and BUSY=1 for exactly one cycle, then go to IDLE. START is ignored in FIN.
- START while BUSY=1 is ignored; it is neither queued nor restarts the operation.
- All arithmetic is modulo 2^32; overflow is discarded with no flag.
- Operand outputs: ALU_X=ACC and ALU_Y=M in CALC; both are 0 in IDLE and FIN. ALU_CONTROL is always 4'b0000.

## Timing
- Reset values: state=IDLE, ACC=M=B=0, CNT=0, PRODUCTO=0, BUSY=0, DONE=0, ALU_REQ=0, ALU_X=ALU_Y=0.
- RESET asserted mid-operation aborts at once to IDLE. PRODUCTO clears to 0 and no DONE is produced.
- START is accepted at edge k. CALC then occupies N granted cycles, and DONE is high in the cycle after the last granted CALC cycle.
- With continuous grant, DONE is high at edge k+N+1.
- N=32 when EARLY_EXIT=0.
- N=max(1, position of the highest set bit of OPB + 1) when EARLY_EXIT=1. OPB=0 gives N=1.
- Each cycle with ALU_GNT=0 adds exactly one cycle of latency. There is no upper bound on stall length.
- The earliest next accepted START is the cycle after FIN, so back-to-back throughput is N+2 cycles per operation.
- PRODUCTO is valid from the DONE cycle onward and is stable until the next FIN.

## Test plan
- OPA=7, OPB=6, EARLY_EXIT=1, GNT tied high → PRODUCTO=42, DONE pulse 4 cycles after START sampled (N=3), BUSY high 4 cycles.
- OPA=0xFFFFFFFD (−3), OPB=5 → PRODUCTO=0xFFFFFFF1. Then OPA=OPB=0xFFFFFFFF → PRODUCTO=0x00000001, with DONE at k+33 (N=32).
- OPB=0, OPA=0x12345678, EARLY_EXIT=1 → DONE at k+2, PRODUCTO=0. Same operands with EARLY_EXIT=0 → DONE at k+33, PRODUCTO=0.
- OPA=3, OPB=0x80000001, GNT low on 5 scattered CALC cycles → PRODUCTO=0x80000003, DONE delayed by exactly 5 cycles, ALU_REQ high throughout CALC.
- START pulsed again during CALC with different operands → ignored; the result still matches the first operands and exactly one DONE is produced.
- RESET asserted at iteration 10 of a 32-iteration run → all outputs at their reset values immediately, no DONE. A new START then completes correctly.
